// File: rtl/teras_pkg.sv
// Shared constants for the teras result reader: default word width, register word indices
// and STATUS/CTRL bit positions.
package teras_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 8;

  // Register selects are word indices, i.e. wbs_adr_i[3:2].
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int unsigned ST_EMPTY     = 16;
  localparam int unsigned ST_FULL      = 17;
  localparam int unsigned ST_UNDERFLOW = 18;
  localparam int unsigned ST_OVERFLOW  = 19;

  localparam int unsigned CTRL_FLUSH  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_CLR    = 2;

endpackage

// File: rtl/teras_result_reader_if.sv
// Engine result stream plus Wishbone slave window of the teras result reader.
interface teras_result_reader_if #(
  parameter int unsigned DATA_W = 32
);
  logic              rts_i;
  logic              rtr_o;
  logic [DATA_W-1:0] data_i;
  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [3:0]        wbs_adr_i;
  logic [31:0]       wbs_dat_i;
  logic [31:0]       wbs_dat_o;
  logic              wbs_ack_o;
  logic              irq_o;

  modport slave (
    input  rts_i, data_i, wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    output rtr_o, wbs_dat_o, wbs_ack_o, irq_o
  );

  modport master (
    output rts_i, data_i, wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    input  rtr_o, wbs_dat_o, wbs_ack_o, irq_o
  );
endinterface

// File: rtl/teras_rd_fifo.sv
// Synchronous FIFO with flush; head word is presented combinationally on o_data.
module teras_rd_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push, w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Flush wins over both ports; DEPTH is a power of two so pointers wrap naturally.
  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/teras_result_reader.sv
// Buffers teras engine results in a FIFO and exposes them over a Wishbone slave window.
// Optional level interrupt enabled by defining TERAS_READER_IRQ_EN.
module teras_result_reader
  import teras_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input logic                   clk,
  input logic                   rst_n,
  teras_result_reader_if.slave  bus
);
  logic [DATA_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full, w_empty;
  logic              w_req, w_rd, w_wr, w_data_rd, w_ctrl_wr, w_pop, w_push, w_rtr;
  logic              w_irq_en;
  logic [1:0]        w_sel;
  logic [31:0]       w_status, w_ctrl, w_rdata;
  logic              w_unused;

  logic              r_ack, r_flush, r_alive, r_uf, r_ov;
  logic [31:0]       r_dat;

  assign w_req     = bus.wbs_cyc_i && bus.wbs_stb_i && !r_ack;
  assign w_sel     = bus.wbs_adr_i[3:2];
  assign w_rd      = w_req && !bus.wbs_we_i;
  assign w_wr      = w_req && bus.wbs_we_i;
  assign w_data_rd = w_rd && (w_sel == REG_DATA);
  assign w_ctrl_wr = w_wr && (w_sel == REG_CTRL);
  assign w_pop     = w_data_rd && !w_empty && !r_flush;
  // rtr depends only on registered state, so Wishbone never reaches it combinationally.
  assign w_rtr     = r_alive && !w_full && !r_flush;
  assign w_push    = bus.rts_i && w_rtr;
  assign w_unused  = ^{bus.wbs_adr_i[1:0], bus.wbs_dat_i};

  teras_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (r_flush),
    .i_data  (bus.data_i),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_status                  = '0;
    w_status[CNT_W-1:0]       = w_count;
    w_status[ST_EMPTY]        = w_empty;
    w_status[ST_FULL]         = w_full;
    w_status[ST_UNDERFLOW]    = r_uf;
    w_status[ST_OVERFLOW]     = r_ov;
    w_ctrl                    = '0;
    w_ctrl[CTRL_IRQ_EN]       = w_irq_en;
    w_rdata                   = '0;
    case (w_sel)
      REG_DATA:   w_rdata = w_empty ? 32'h0 : 32'(w_head);
      REG_STATUS: w_rdata = w_status;
      REG_CTRL:   w_rdata = w_ctrl;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_flush <= 1'b0;
      r_alive <= 1'b0;
      r_uf    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_ack   <= w_req;
      r_dat   <= w_rd ? w_rdata : 32'h0;
      r_flush <= w_ctrl_wr && bus.wbs_dat_i[CTRL_FLUSH];
      r_alive <= 1'b1;
      // A new event in the same cycle as a clear is kept rather than lost.
      r_uf <= (r_uf && !(w_ctrl_wr && bus.wbs_dat_i[CTRL_CLR])) || (w_data_rd && w_empty);
      r_ov <= (r_ov && !(w_ctrl_wr && bus.wbs_dat_i[CTRL_CLR])) || (bus.rts_i && w_full);
    end
  end

`ifdef TERAS_READER_IRQ_EN
  logic r_irq_en, r_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= bus.wbs_dat_i[CTRL_IRQ_EN];
      r_irq <= r_irq_en && (!w_empty || r_uf || r_ov);
    end
  end

  assign w_irq_en  = r_irq_en;
  assign bus.irq_o = r_irq;
`else
  assign w_irq_en  = 1'b0;
  assign bus.irq_o = 1'b0;
`endif

  assign bus.rtr_o     = w_rtr;
  assign bus.wbs_ack_o = r_ack;
  assign bus.wbs_dat_o = r_dat;
endmodule

// File: tb/tb_teras_result_reader.sv
// Scoreboard bench for teras_result_reader; irq expectations follow TERAS_READER_IRQ_EN.
module tb_teras_result_reader;
  localparam int unsigned DEPTH = 8;
  localparam logic [3:0] A_DATA = 4'h0, A_STATUS = 4'h4, A_CTRL = 4'h8, A_RSVD = 4'hC;
`ifdef TERAS_READER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] sb[$];

  teras_result_reader_if #(.DATA_W(32)) bus ();

  teras_result_reader #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Bus access; called and returns at 1ns after a rising edge.
  task automatic wb_access(input logic we, input logic [3:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
    bit got = 0;
    rdat = '0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = wdat;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin got = 1; rdat = bus.wbs_dat_o; end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL wb_ack adr=%h: ack got 0 required 1", adr);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    bit got = 0;
    bit acc;
    bus.data_i = w; bus.rts_i = 1'b1;
    for (int i = 0; i < 16 && !got; i++) begin
      acc = bus.rtr_o;
      @(posedge clk); #1;
      if (acc) begin got = 1; sb.push_back(w); end
    end
    bus.rts_i = 1'b0;
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL push_timeout: word %h not accepted, rtr got 0 required 1", w);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.rtr_o !== 1'b0) begin n_errors++; $display("FAIL reset_rtr: got %b required 0", bus.rtr_o); end
    n_checks++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0 || bus.irq_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: ack=%b dat=%h irq=%b required 0/0/0",
               bus.wbs_ack_o, bus.wbs_dat_o, bus.irq_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.rtr_o !== 1'b1) begin n_errors++; $display("FAIL reset_rtr_release: got %b required 1", bus.rtr_o); end
    wb_access(1'b0, A_STATUS, 32'h0, d);
    n_checks++;
    if (d !== 32'h0001_0000) begin n_errors++; $display("FAIL reset_status: got %h required %h", d, 32'h0001_0000); end
  endtask

  task automatic test_basic();
    logic [31:0] d, e;
    for (int i = 1; i <= 3; i++) push_word(32'hA5A5_0000 + 32'(i));
    wb_access(1'b0, A_STATUS, 32'h0, d);
    n_checks++;
    if (d !== 32'h0000_0003) begin n_errors++; $display("FAIL basic_status3: got %h required %h", d, 32'h3); end
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      wb_access(1'b0, A_DATA, 32'h0, d);
      n_checks++;
      if (d !== e) begin n_errors++; $display("FAIL basic_data%0d: got %h required %h", i, d, e); end
    end
    wb_access(1'b0, A_STATUS, 32'h0, d);
    n_checks++;
    if (d !== 32'h0001_0000) begin n_errors++; $display("FAIL basic_empty: got %h required %h", d, 32'h0001_0000); end
  endtask

  task automatic test_full();
    logic [31:0] d, e;
    int k = 0;
    bit acc;
    bus.rts_i = 1'b1;
    for (int c = 0; c < 20 && k < DEPTH; c++) begin
      bus.data_i = 32'h0000_1000 + 32'(k);
      acc = bus.rtr_o;
      @(posedge clk); #1;
      if (acc) begin sb.push_back(bus.data_i); k++; end
    end
    bus.data_i = 32'h0000_1008;
    @(posedge clk); #1;
    n_checks++;
    if (bus.rtr_o !== 1'b0) begin n_errors++; $display("FAIL full_rtr: got %b required 0", bus.rtr_o); end
    wb_access(1'b0, A_STATUS, 32'h0, d);
    n_checks++;
    if (d !== 32'h000A_0008) begin n_errors++; $display("FAIL full_status: got %h required %h", d, 32'h000A_0008); end
    e = sb.pop_front();
    wb_access(1'b0, A_DATA, 32'h0, d);
    n_checks++;
    if (d !== e) begin n_errors++; $display("FAIL full_pop: got %h required %h", d, e); end
    n_checks++;
    if (bus.rtr_o !== 1'b1) begin n_errors++; $display("FAIL full_rtr_after_pop: got %b required 1", bus.rtr_o); end
    @(posedge clk); #1;
    sb.push_back(32'h0000_1008);
    bus.rts_i = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wb_access(1'b0, A_DATA, 32'h0, d);
      n_checks++;
      if (d !== e) begin n_errors++; $display("FAIL full_drain: got %h required %h", d, e); end
    end
    wb_access(1'b0, A_STATUS, 32'h0, d);
    n_checks++;
    if (d !== 32'h0009_0000) begin n_errors++; $display("FAIL full_sticky: got %h required %h", d, 32'h0009_0000); end
    wb_access(1'b1, A_CTRL, 32'h4, d);
  endtask

  task automatic test_underflow();
    logic [31:0] d;
    wb_access(1'b0, A_DATA, 32'h0, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL uf_data: got %h required 0", d); end
    wb_access(1'b0, A_STATUS, 32'h0, d);
    n_checks++;
    if (d !== 32'h0005_0000) begin n_errors++; $display("FAIL uf_status: got %h required %h", d, 32'h0005_0000); end
    wb_access(1'b1, A_CTRL, 32'h4, d);
    wb_access(1'b1, A_RSVD, 32'hFFFF_FFFF, d);
    wb_access(1'b1, A_DATA, 32'h0000_FFFF, d);
    wb_access(1'b0, A_STATUS, 32'h0, d);
    n_checks++;
    if (d !== 32'h0001_0000) begin n_errors++; $display("FAIL uf_clear: got %h required %h", d, 32'h0001_0000); end
    wb_access(1'b0, A_RSVD, 32'h0, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL rsvd_read: got %h required 0", d); end
    wb_access(1'b0, A_CTRL, 32'h0, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL ctrl_read: got %h required 0", d); end
  endtask

  task automatic test_flush();
    logic [31:0] d, e;
    for (int i = 0; i < 5; i++) push_word(32'h0000_5500 + 32'(i));
    bus.data_i = 32'h0000_00F1;
    bus.rts_i  = 1'b1;
    wb_access(1'b1, A_CTRL, 32'h1, d);
    n_checks++;
    if (bus.rtr_o !== 1'b0) begin n_errors++; $display("FAIL flush_rtr: got %b required 0", bus.rtr_o); end
    @(posedge clk); #1;
    bus.rts_i = 1'b0;
    sb.delete();
    wb_access(1'b0, A_STATUS, 32'h0, d);
    n_checks++;
    if (d !== 32'h0001_0000) begin n_errors++; $display("FAIL flush_status: got %h required %h", d, 32'h0001_0000); end
    push_word(32'h0000_BEEF);
    e = sb.pop_front();
    wb_access(1'b0, A_DATA, 32'h0, d);
    n_checks++;
    if (d !== e) begin n_errors++; $display("FAIL flush_next: got %h required %h", d, e); end
  endtask

  task automatic test_irq();
    logic [31:0] d, e;
    wb_access(1'b1, A_CTRL, 32'h2, d);
    wb_access(1'b0, A_CTRL, 32'h0, d);
    n_checks++;
    if (d !== (IRQ_ON ? 32'h2 : 32'h0)) begin n_errors++; $display("FAIL irq_ctrl_read: got %h required %h", d, IRQ_ON ? 32'h2 : 32'h0); end
    n_checks++;
    if (bus.irq_o !== 1'b0) begin n_errors++; $display("FAIL irq_idle: got %b required 0", bus.irq_o); end
    push_word(32'h0000_0077);
    @(posedge clk); #1;
    n_checks++;
    if (bus.irq_o !== IRQ_ON) begin n_errors++; $display("FAIL irq_raise: got %b required %b", bus.irq_o, IRQ_ON); end
    e = sb.pop_front();
    wb_access(1'b0, A_DATA, 32'h0, d);
    n_checks++;
    if (d !== e) begin n_errors++; $display("FAIL irq_data: got %h required %h", d, e); end
    @(posedge clk); #1;
    n_checks++;
    if (bus.irq_o !== 1'b0) begin n_errors++; $display("FAIL irq_drop: got %b required 0", bus.irq_o); end
    wb_access(1'b1, A_CTRL, 32'h0, d);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    fork
      begin : pusher
        int idx = 0;
        bit acc;
        bus.rts_i = 1'b1;
        bus.data_i = 32'hC0DE_0000;
        #1;
        for (int c = 0; c < 300 && idx < 20; c++) begin
          acc = bus.rtr_o;
          n_checks++;
          if (acc !== (sb.size() < DEPTH)) begin
            n_errors++;
            $display("FAIL b2b_rtr: got %b required %b (model count %0d)", acc, sb.size() < DEPTH, sb.size());
          end
          @(posedge clk);
          if (acc) begin sb.push_back(bus.data_i); idx++; end
          #2;
          if (idx < 20) bus.data_i = 32'hC0DE_0000 + 32'(idx);
          else bus.rts_i = 1'b0;
        end
        bus.rts_i = 1'b0;
      end
      begin : reader
        logic [31:0] r, e;
        for (int c = 0; c < 50 && sb.size() < 3; c++) begin @(posedge clk); #1; end
        for (int i = 0; i < 20; i++) begin
          wb_access(1'b0, A_DATA, 32'h0, r);
          n_checks++;
          if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL b2b_extra: got %h required nothing (scoreboard empty)", r);
          end else begin
            e = sb.pop_front();
            if (r !== e) begin n_errors++; $display("FAIL b2b_data%0d: got %h required %h", i, r, e); end
          end
        end
      end
    join
    n_checks++;
    if (sb.size() != 0) begin n_errors++; $display("FAIL b2b_left: got %0d words unread required 0", sb.size()); end
    wb_access(1'b0, A_STATUS, 32'h0, d);
    n_checks++;
    if ((d & 32'h0003_FFFF) !== 32'h0001_0000) begin
      n_errors++;
      $display("FAIL b2b_status: got %h required %h (low 18 bits)", d & 32'h0003_FFFF, 32'h0001_0000);
    end
  endtask

  initial begin
    bus.rts_i = 1'b0; bus.data_i = '0;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
    test_reset();
    test_basic();
    test_full();
    test_underflow();
    test_flush();
    test_irq();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
